// File: rtl/cv32e40p_pkg.sv
// Shared cv32e40p definitions used by the bit-scan sequencer.
package cv32e40p_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } bitscan_state_e;

endpackage

// File: rtl/cv32e40p_ff_one.sv
// Find-first-one encoder: position of the lowest set bit of in_i (0 when none set).
module cv32e40p_ff_one #(
  parameter int unsigned LEN = 32,
  localparam int unsigned IDXW = $clog2(LEN)
) (
  input  logic [LEN-1:0]  in_i,
  output logic [IDXW-1:0] first_one_o,
  output logic            no_ones_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    first_one_o = '0;
    for (int i = LEN - 1; i >= 0; i--) begin
      if (in_i[i]) first_one_o = IDXW'(i);
    end
  end

  assign no_ones_o = ~|in_i;

endmodule

// File: rtl/cv32e40p_bitscan_seq.sv
// Loads a bit vector and emits the indices of its set bits, lowest first, one per cycle.
module cv32e40p_bitscan_seq
  import cv32e40p_pkg::*;
#(
  parameter int unsigned LEN = 32,
  localparam int unsigned IDXW = $clog2(LEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            load_valid_i,
  input  logic [LEN-1:0]  load_vec_i,
  output logic            load_ready_o,
  output logic            idx_valid_o,
  input  logic            idx_ready_i,
  output logic [IDXW-1:0] idx_o,
  output logic            idx_last_o,
  output logic            done_o,
  output logic            busy_o
);

  localparam logic [LEN-1:0] ONE = LEN'(1);

  bitscan_state_e  state_q, state_d;
  logic [LEN-1:0]  pending_q, pending_d;
  logic            done_q, done_d;
  logic [IDXW-1:0] first_one;
  logic            no_ones;

  cv32e40p_ff_one #(.LEN(LEN)) u_ff_one (
    .in_i        (pending_q),
    .first_one_o (first_one),
    .no_ones_o   (no_ones)
  );

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high and flush_i is low; valid never depends on ready, and once
  // raised, valid and its payload hold until the transfer completes.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    if (flush_i) begin
      state_d   = IDLE;
      pending_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid_i) begin
            if (|load_vec_i) begin
              pending_d = load_vec_i;
              state_d   = SCAN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        SCAN: begin
          if (idx_ready_i) begin
            pending_d = pending_q & ~(ONE << first_one);
            if (idx_last_o) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  assign busy_o       = (state_q == SCAN);
  assign load_ready_o = (state_q == IDLE);
  assign idx_valid_o  = busy_o;
  assign idx_o        = first_one;
  assign idx_last_o   = busy_o && ((pending_q & (pending_q - ONE)) == '0);
  assign done_o       = done_q;

  // In SCAN the pending vector is never empty, so a valid index always exists.
  assert property (@(posedge clk) disable iff (rst) idx_valid_o |-> !no_ones);

endmodule

// File: doc/cv32e40p_bitscan_seq.md
CV32E40P_BITSCAN_SEQ -- requirements
Module: cv32e40p_bitscan_seq

Interface
REQ-001 SHALL have parameter LEN, default 32, giving the request vector width (power of two, 2..64).
REQ-002 SHALL have localparam IDXW, equal to $clog2(LEN), giving the index width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port flush_i, input, 1 bit: abort the current scan.
REQ-006 SHALL have port load_valid_i, input, 1 bit: a new vector is offered.
REQ-007 SHALL have port load_vec_i, input, LEN bits: the vector to scan.
REQ-008 SHALL have port load_ready_o, output, 1 bit: the block can accept a vector.
REQ-009 SHALL have port idx_valid_o, output, 1 bit: idx_o holds a valid set-bit index.
REQ-010 SHALL have port idx_ready_i, input, 1 bit: the consumer accepts the index.
REQ-011 SHALL have port idx_o, output, IDXW bits: lowest set-bit position still pending.
REQ-012 SHALL have port idx_last_o, output, 1 bit: the current index is the final pending bit.
REQ-013 SHALL have port done_o, output, 1 bit: one-cycle pulse when a scan finishes.
REQ-014 SHALL have port busy_o, output, 1 bit: the block is in state SCAN.

Function
REQ-015 SHALL implement two states: IDLE and SCAN.
REQ-016 SHALL assert load_ready_o in IDLE only.
REQ-017 SHALL, on a load handshake (IDLE, load_valid_i=1, flush_i=0) with a nonzero vector, register load_vec_i into pending_q and enter SCAN on the next cycle.
REQ-018 SHALL, on a load handshake with an all-zero vector, stay in IDLE and pulse done_o on the next cycle; no index is emitted.
REQ-019 SHALL assert idx_valid_o in SCAN only, with idx_o equal to the lowest set bit of pending_q (combinational from the register). First index is visible 1 cycle after load.
REQ-020 SHALL hold idx_valid_o and idx_o stable while idx_ready_i=0.
REQ-021 SHALL, on an index handshake, clear bit idx_o of pending_q on that edge; the next index is visible in the following cycle, sustaining 1 index/cycle.
REQ-022 SHALL drive idx_last_o high in SCAN when pending_q has exactly one bit set, computed as (pending_q & (pending_q-1)) == 0.
REQ-023 SHALL, on an index handshake with idx_last_o=1, return to IDLE and pulse done_o for exactly 1 cycle in the next cycle.
REQ-024 SHALL make flush_i take priority over both handshakes: clear pending_q, go to IDLE, and pulse no done_o. A load offered in the same cycle is not accepted.
REQ-025 SHALL accept a new load in the cycle in which done_o is high (IDLE); there are no back-to-back bubbles beyond the single IDLE cycle.
REQ-026 SHALL, for LEN bit LEN-1 set, produce idx_o=LEN-1 with no wrap.
REQ-027 SHALL never raise idx_valid_o with pending_q=0; the find-first-one no-ones flag is unused except by assertions.

Reset
REQ-028 SHALL, with rst=1 at a clock edge, force state to IDLE, pending_q to 0 and done_o to 0.
REQ-029 SHALL give the following output values during and after reset: load_ready_o=1, idx_valid_o=0, idx_o=0, idx_last_o=0, busy_o=0.
REQ-030 SHALL, when rst is asserted mid-scan, discard the pending bits with no done_o pulse.

Structure
REQ-031 SHALL place the state enum (IDLE, SCAN) in the shared cv32e40p package.
REQ-032 SHALL instantiate the existing find-first-one encoder cv32e40p_ff_one (LEN) on pending_q as its only sub-module.
REQ-033 SHALL use a single always_ff for state, pending_q and done_o; all other logic is combinational.

Verification
REQ-034 SHALL cover: load 32'h8000_0011, idx_ready_i=1 -> idx_o 0,4,31 on consecutive cycles; idx_last_o only with 31; done_o pulse the cycle after.
REQ-035 SHALL cover: load 32'h0000_0000 -> no idx_valid_o; done_o high 1 cycle later; load_ready_o stays 1.
REQ-036 SHALL cover: load 32'h0000_0006, idx_ready_i=0 for 3 cycles -> idx_o holds 1, then 1,2 after ready; idx_last_o with 2.
REQ-037 SHALL cover: load 32'hFFFF_FFFF, flush_i after 5 indices -> next cycle IDLE, load_ready_o=1, no done_o.
REQ-038 SHALL cover: rst pulse mid-scan of 32'h00F0_0000 -> all outputs return to reset values; the next load 32'h1 yields idx_o=0 with idx_last_o=1.
REQ-039 SHALL cover: flush_i and load_valid_i together in IDLE -> the load is not accepted; the state remains IDLE.
